// File: rtl/stream_demux_if.sv
// One 8-bit valid/ready/last byte stream; the master drives data, the slave drives ready.
interface stream_demux_if;
  logic       valid;
  logic       last;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/stream_demux.sv
// 1:2 packet demultiplexer: the header beat picks the port and is consumed, and payload beats
// go out through a one-entry register per port with full backpressure.
module stream_demux #(
  parameter int DEST_BIT = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_demux_if.slave      s,
  stream_demux_if.master     m0,
  stream_demux_if.master     m1,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic {HDR, PAY} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t state;
  logic   sel;
  logic   sel_valid;
  logic   sel_ready;
  logic   s_ready_int;
  logic   in_xfer;
  logic   load0;
  logic   load1;

  assign sel_valid = sel ? m1.valid : m0.valid;
  assign sel_ready = sel ? m1.ready : m0.ready;

  // Headers are always accepted, because they never occupy an output register.
  always_comb begin
    s_ready_int = 1'b0;
    if (rst_n) begin
      if (state == HDR) s_ready_int = 1'b1;
      else              s_ready_int = ~sel_valid | sel_ready;
    end
  end

  assign s.ready  = s_ready_int;
  assign in_xfer  = s.valid & s_ready_int;
  assign load0    = in_xfer & (state == PAY) & ~sel;
  assign load1    = in_xfer & (state == PAY) &  sel;
  assign busy     = (state == PAY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HDR;
      sel      <= 1'b0;
      drop_cnt <= '0;
      m0.valid <= 1'b0;
      m0.last  <= 1'b0;
      m0.data  <= 8'h00;
      m1.valid <= 1'b0;
      m1.last  <= 1'b0;
      m1.data  <= 8'h00;
    end else begin
      case (state)
        HDR: begin
          if (in_xfer) begin
            if (s.last) begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
            end else begin
              sel   <= s.data[DEST_BIT];
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (in_xfer && s.last) state <= HDR;
        end
        default: state <= HDR;
      endcase

      // A load wins over a drain, so one beat per cycle can flow straight through.
      if (load0) begin
        m0.valid <= 1'b1;
        m0.last  <= s.last;
        m0.data  <= s.data;
      end else if (m0.valid && m0.ready) begin
        m0.valid <= 1'b0;
      end

      if (load1) begin
        m1.valid <= 1'b1;
        m1.last  <= s.last;
        m1.data  <= s.data;
      end else if (m1.valid && m1.ready) begin
        m1.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: dut_a uses the default parameters, while dut_b uses DEST_BIT=7 and CNT_W=2.
module tb_stream_demux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_demux_if sa ();
  stream_demux_if m0a ();
  stream_demux_if m1a ();
  stream_demux_if sb ();
  stream_demux_if m0b ();
  stream_demux_if m1b ();

  logic       busy_a;
  logic       busy_b;
  logic [7:0] drop_a;
  logic [1:0] drop_b;

  stream_demux #(.DEST_BIT(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(sa), .m0(m0a), .m1(m1a),
    .busy(busy_a), .drop_cnt(drop_a)
  );

  stream_demux #(.DEST_BIT(7), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(sb), .m0(m0b), .m1(m1b),
    .busy(busy_b), .drop_cnt(drop_b)
  );

  // Inputs change just after the falling edge, so every check lands mid-cycle away from the rising edge.
  task automatic applyStimulus(input logic rst, input bit to_b, input logic v, input logic l,
                               input logic [7:0] d, input logic r0, input logic r1);
    @(negedge clk);
    rst_n = rst;
    if (to_b) begin
      sb.valid = v;    sb.last = l;    sb.data = d;
      m0b.ready = r0;  m1b.ready = r1;
      sa.valid = 1'b0; sa.last = 1'b0; sa.data = 8'h00;
      m0a.ready = 1'b1; m1a.ready = 1'b1;
    end else begin
      sa.valid = v;    sa.last = l;    sa.data = d;
      m0a.ready = r0;  m1a.ready = r1;
      sb.valid = 1'b0; sb.last = 1'b0; sb.data = 8'h00;
      m0b.ready = 1'b1; m1b.ready = 1'b1;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    sa.valid = 1'b0; sa.last = 1'b0; sa.data = 8'h00; m0a.ready = 1'b1; m1a.ready = 1'b1;
    sb.valid = 1'b0; sb.last = 1'b0; sb.data = 8'h00; m0b.ready = 1'b1; m1b.ready = 1'b1;

    // Reset state.
    applyStimulus(0, 0, 1, 0, 8'h00, 1, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 1, 1);
    checkOutput("rst_s_ready", sa.ready, 0);
    checkOutput("rst_m0_valid", m0a.valid, 0);
    checkOutput("rst_m1_valid", m1a.valid, 0);
    checkOutput("rst_m0_data", m0a.data, 0);
    checkOutput("rst_m0_last", m0a.last, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_drop", drop_a, 0);

    // Single packet to port 0.
    applyStimulus(1, 0, 1, 0, 8'h00, 1, 1);
    checkOutput("p1_hdr_ready", sa.ready, 1);
    checkOutput("p1_hdr_busy", busy_a, 0);
    applyStimulus(1, 0, 1, 0, 8'h11, 1, 1);
    checkOutput("p1_b0_busy", busy_a, 1);
    checkOutput("p1_b0_m0v", m0a.valid, 0);
    checkOutput("p1_b0_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 0, 8'h22, 1, 1);
    checkOutput("p1_b1_busy", busy_a, 1);
    checkOutput("p1_b1_m0v", m0a.valid, 1);
    checkOutput("p1_b1_m0d", m0a.data, 8'h11);
    checkOutput("p1_b1_m0l", m0a.last, 0);
    applyStimulus(1, 0, 1, 1, 8'h33, 1, 1);
    checkOutput("p1_b2_busy", busy_a, 1);
    checkOutput("p1_b2_m0d", m0a.data, 8'h22);
    checkOutput("p1_b2_m1v", m1a.valid, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("p1_end_busy", busy_a, 0);
    checkOutput("p1_end_m0v", m0a.valid, 1);
    checkOutput("p1_end_m0d", m0a.data, 8'h33);
    checkOutput("p1_end_m0l", m0a.last, 1);
    checkOutput("p1_end_m1v", m1a.valid, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("p1_drain_m0v", m0a.valid, 0);

    // Back-to-back packets to port 1 then port 0.
    applyStimulus(1, 0, 1, 0, 8'h01, 1, 1);
    checkOutput("p2_hdr_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 0, 8'hA0, 1, 1);
    checkOutput("p2_a0_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 1, 8'hA1, 1, 1);
    checkOutput("p2_a1_ready", sa.ready, 1);
    checkOutput("p2_a1_m1v", m1a.valid, 1);
    checkOutput("p2_a1_m1d", m1a.data, 8'hA0);
    applyStimulus(1, 0, 1, 0, 8'h00, 1, 1);
    checkOutput("p3_hdr_ready", sa.ready, 1);
    checkOutput("p3_hdr_m1d", m1a.data, 8'hA1);
    checkOutput("p3_hdr_m1l", m1a.last, 1);
    applyStimulus(1, 0, 1, 1, 8'hB0, 1, 1);
    checkOutput("p3_b0_ready", sa.ready, 1);
    checkOutput("p3_b0_m1v", m1a.valid, 0);
    checkOutput("p3_b0_m0v", m0a.valid, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("p3_end_m0v", m0a.valid, 1);
    checkOutput("p3_end_m0d", m0a.data, 8'hB0);
    checkOutput("p3_end_m0l", m0a.last, 1);
    checkOutput("p3_end_m1v", m1a.valid, 0);

    // Port 0 backpressure, where input data advances only after an accepted beat.
    applyStimulus(1, 0, 1, 0, 8'h00, 1, 1);
    applyStimulus(1, 0, 1, 0, 8'hC0, 0, 1);
    checkOutput("bp_c0_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 0, 8'hC1, 0, 1);
    checkOutput("bp_stall1_ready", sa.ready, 0);
    checkOutput("bp_stall1_m0d", m0a.data, 8'hC0);
    applyStimulus(1, 0, 1, 0, 8'hC1, 1, 1);
    checkOutput("bp_go1_ready", sa.ready, 1);
    checkOutput("bp_go1_m0d", m0a.data, 8'hC0);
    applyStimulus(1, 0, 1, 0, 8'hC2, 0, 1);
    checkOutput("bp_stall2_ready", sa.ready, 0);
    checkOutput("bp_stall2_m0d", m0a.data, 8'hC1);
    applyStimulus(1, 0, 1, 0, 8'hC2, 0, 1);
    checkOutput("bp_stall3_ready", sa.ready, 0);
    checkOutput("bp_stall3_m0v", m0a.valid, 1);
    checkOutput("bp_stall3_m0d", m0a.data, 8'hC1);
    applyStimulus(1, 0, 1, 0, 8'hC2, 1, 1);
    checkOutput("bp_go2_ready", sa.ready, 1);
    checkOutput("bp_go2_m0d", m0a.data, 8'hC1);
    applyStimulus(1, 0, 1, 1, 8'hC3, 1, 1);
    checkOutput("bp_c3_ready", sa.ready, 1);
    checkOutput("bp_c3_m0d", m0a.data, 8'hC2);
    checkOutput("bp_c3_m0l", m0a.last, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 1);
    checkOutput("bp_end_m0d", m0a.data, 8'hC3);
    checkOutput("bp_end_m0l", m0a.last, 1);
    checkOutput("bp_end_busy", busy_a, 0);
    checkOutput("bp_end_ready", sa.ready, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("bp_hold_m0v", m0a.valid, 1);
    checkOutput("bp_hold_m0d", m0a.data, 8'hC3);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("bp_drain_m0v", m0a.valid, 0);

    // Header-only packets are dropped and counted.
    applyStimulus(1, 0, 1, 1, 8'h00, 1, 1);
    applyStimulus(1, 0, 1, 1, 8'h01, 1, 1);
    checkOutput("drop_1", drop_a, 1);
    applyStimulus(1, 0, 1, 1, 8'h00, 1, 1);
    checkOutput("drop_2", drop_a, 2);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 1);
    checkOutput("drop_3", drop_a, 3);
    checkOutput("drop_m0v", m0a.valid, 0);
    checkOutput("drop_m1v", m1a.valid, 0);
    checkOutput("drop_busy", busy_a, 0);

    // Reset in the middle of a stalled port 1 packet.
    applyStimulus(1, 0, 1, 0, 8'h01, 1, 0);
    applyStimulus(1, 0, 1, 0, 8'hD0, 1, 0);
    checkOutput("mr_d0_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 0, 8'hD1, 1, 0);
    checkOutput("mr_d1_ready", sa.ready, 0);
    checkOutput("mr_d1_m1v", m1a.valid, 1);
    applyStimulus(0, 0, 1, 0, 8'hD1, 1, 0);
    checkOutput("mr_rst_ready", sa.ready, 0);
    applyStimulus(1, 0, 1, 0, 8'h00, 1, 0);
    checkOutput("mr_after_m1v", m1a.valid, 0);
    checkOutput("mr_after_busy", busy_a, 0);
    checkOutput("mr_after_drop", drop_a, 0);
    checkOutput("mr_after_ready", sa.ready, 1);
    applyStimulus(1, 0, 1, 1, 8'h55, 1, 0);
    checkOutput("mr_55_busy", busy_a, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 0);
    checkOutput("mr_end_m0v", m0a.valid, 1);
    checkOutput("mr_end_m0d", m0a.data, 8'h55);
    checkOutput("mr_end_m0l", m0a.last, 1);
    checkOutput("mr_end_m1v", m1a.valid, 0);

    // DEST_BIT=7 routing on dut_b.
    applyStimulus(1, 1, 1, 0, 8'h80, 1, 1);
    applyStimulus(1, 1, 1, 1, 8'h7F, 1, 1);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 1);
    checkOutput("d7_a_m1v", m1b.valid, 1);
    checkOutput("d7_a_m1d", m1b.data, 8'h7F);
    checkOutput("d7_a_m0v", m0b.valid, 0);
    applyStimulus(1, 1, 1, 0, 8'h7F, 1, 1);
    applyStimulus(1, 1, 1, 1, 8'h80, 1, 1);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 1);
    checkOutput("d7_b_m0v", m0b.valid, 1);
    checkOutput("d7_b_m0d", m0b.data, 8'h80);
    checkOutput("d7_b_m1v", m1b.valid, 0);

    // A 2-bit drop counter saturates at 3.
    applyStimulus(1, 1, 1, 1, 8'h00, 1, 1);
    applyStimulus(1, 1, 1, 1, 8'h00, 1, 1);
    checkOutput("sat_1", drop_b, 1);
    applyStimulus(1, 1, 1, 1, 8'h00, 1, 1);
    checkOutput("sat_2", drop_b, 2);
    applyStimulus(1, 1, 1, 1, 8'h00, 1, 1);
    checkOutput("sat_3", drop_b, 3);
    applyStimulus(1, 1, 1, 1, 8'h00, 1, 1);
    checkOutput("sat_4", drop_b, 3);
    applyStimulus(1, 1, 0, 0, 8'h00, 1, 1);
    checkOutput("sat_5", drop_b, 3);
    checkOutput("sat_m0v", m0b.valid, 0);
    checkOutput("sat_m1v", m1b.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1:2 packet demultiplexer for 8-bit valid/ready/last byte streams.
- It is the splitting counterpart of the 2:1 packet mux.
- The first beat of every input packet is a header. Header bit DEST_BIT selects output port 0 or 1. The header is consumed, not forwarded.
- Payload beats are forwarded to the selected port through a one-entry output register per port, with full backpressure. Sits between a packet source and two downstream consumers.

Parameters:
- DEST_BIT, 0, header bit index (0..7) that selects the port: 0 -> port 0, 1 -> port 1.
- CNT_W, 8, width of the saturating dropped-packet counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- s_valid  input  1  input beat valid.
- s_last  input  1  input beat is last of packet.
- s_data  input  8  input beat data.
- s_ready  output  1  demux can accept input beat this cycle.
- m0_valid  output  1  port 0 beat valid (registered).
- m0_last  output  1  port 0 last (registered).
- m0_data  output  8  port 0 data (registered).
- m0_ready  input  1  port 0 consumer ready.
- m1_valid  output  1  port 1 beat valid (registered).
- m1_last  output  1  port 1 last (registered).
- m1_data  output  8  port 1 data (registered).
- m1_ready  input  1  port 1 consumer ready.
- busy  output  1  high while in PAY state (mid-packet).
- drop_cnt  output  CNT_W  header-only packets dropped; saturates at all-ones.

Behaviour:
- Transfer rules:
  - Input transfer: s_valid && s_ready at a rising edge.
  - Output transfer on port k: mk_valid && mk_ready.
- Reset (rst_n=0 at edge):
  - m0/m1 valid=0, last=0, data=0; state=HDR; sel=0; drop_cnt=0.
  - s_ready=0 while rst_n=0 (combinational gate).
  - Reset mid-packet abandons the packet and any registered beats. The first beat after reset is treated as a header.
- State HDR:
  - s_ready=1 regardless of output occupancy.
  - On header transfer with s_last=0: sel <= s_data[DEST_BIT]; state -> PAY.
  - On header transfer with s_last=1: packet has no payload. It is dropped, drop_cnt increments (saturating), state stays HDR.
  - Header never appears on any output.
- State PAY:
  - s_ready = ~m_sel_valid | m_sel_ready. Combinational from the selected port's register and ready only.
  - On payload transfer, the selected port's register loads s_data/s_last and valid=1, visible the next cycle (latency 1).
  - On payload transfer with s_last=1: state -> HDR.
  - busy=1 exactly in PAY.
- Output register per port:
  - If mk_valid && mk_ready and no new load: valid <= 0.
  - Load and drain in the same cycle: the register takes the new beat, valid stays 1. Sustains 1 beat/cycle.
  - While mk_valid=1 and mk_ready=0: data, last and valid are held stable. Valid is never withdrawn before a transfer.
- Unselected port: drains its pending beat independently. It is never loaded until selected by a later header.
- Per-packet overhead:
  - Exactly one header cycle; no other bubbles when consumers are always ready.
  - Back-to-back packets to different ports may have both outputs valid simultaneously.
- Ordering: beats on each port appear in input order. Packets are never interleaved on a port.
- s_ready does not depend on s_valid, so there is no combinational loop.

Test Plan:
- Reset, then packet [hdr=0x00, 0x11, 0x22, 0x33(last)], m0_ready=m1_ready=1 -> m0 emits 0x11, 0x22, 0x33 with last on 0x33 on consecutive cycles starting 1 cycle after each accept. m1_valid stays 0; busy high 3 cycles.
- Two back-to-back packets [0x01, 0xA0, 0xA1(last)] then [0x00, 0xB0(last)], both readys=1 -> 0xA0, 0xA1 on m1, 0xB0 on m0. Total 5 input cycles, s_ready continuously 1.
- Port 0 packet of 4 payload beats with m0_ready toggling 1,0,0,1,... -> s_ready low exactly when m0_valid=1 and m0_ready=0. m0 data/last stable while stalled; all 4 bytes delivered in order, none lost or duplicated.
- Header-only packets: three beats 0x00(last), 0x01(last), 0x00(last) -> no output valid; drop_cnt=3. With CNT_W=2, five such packets -> drop_cnt saturates at 3.
- Reset asserted mid-packet after 2 payload beats on port 1 with m1_ready=0 -> next cycle m1_valid=0, state HDR, drop_cnt=0. Next beat 0x00 then 0x55(last) routes 0x55 to port 0.
- DEST_BIT=7, header 0x80 then 0x7F(last) -> 0x7F on m1. Header 0x7F then 0x80(last) -> 0x80 on m0.
